// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a two-state handshake FSM and a sticky ack-timeout flag
module memory_stage #(
  parameter int WIDTH = 24,
  parameter int REG_BITS = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [WIDTH-1:0]    alu_result_in,
  input  logic [WIDTH-1:0]    write_data_in,
  input  logic [REG_BITS-1:0] write_register_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                mem_reg_in,
  input  logic                reg_write_in,
  output logic                stall_out,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic                mem_ack,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [WIDTH-1:0]    read_data_out,
  output logic [WIDTH-1:0]    alu_result_out,
  output logic [REG_BITS-1:0] write_register_out,
  output logic                mem_reg_out,
  output logic                reg_write_out,
  output logic                valid_out,
  output logic                mem_error
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] cap_alu, cap_wdata;
  logic [REG_BITS-1:0] cap_wreg;
  logic cap_rd, cap_wr, cap_mreg, cap_rw;
  logic mem_op, expire;
  assign mem_op = valid_in & (mem_read_in | mem_write_in);
  assign expire = cnt == CW'(TIMEOUT - 1);
  assign stall_out = (state == IDLE) ? mem_op : ~mem_ack;
  assign mem_req = state == ACCESS;
  assign mem_we = cap_wr;
  assign mem_addr = cap_alu;
  assign mem_wdata = cap_wdata;
  // FSM: pass ALU ops straight through, hold memory ops in ACCESS until ack or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cap_alu <= '0;
      cap_wdata <= '0;
      cap_wreg <= '0;
      cap_rd <= 1'b0;
      cap_wr <= 1'b0;
      cap_mreg <= 1'b0;
      cap_rw <= 1'b0;
      read_data_out <= '0;
      alu_result_out <= '0;
      write_register_out <= '0;
      mem_reg_out <= 1'b0;
      reg_write_out <= 1'b0;
      valid_out <= 1'b0;
      mem_error <= 1'b0;
    end else if (state == IDLE) begin
      valid_out <= 1'b0;
      if (mem_op) begin
        state <= ACCESS;
        cnt <= '0;
        cap_alu <= alu_result_in;
        cap_wdata <= write_data_in;
        cap_wreg <= write_register_in;
        cap_rd <= mem_read_in;
        cap_wr <= mem_write_in;
        cap_mreg <= mem_reg_in;
        cap_rw <= reg_write_in;
      end else if (valid_in) begin
        alu_result_out <= alu_result_in;
        write_register_out <= write_register_in;
        mem_reg_out <= mem_reg_in;
        reg_write_out <= reg_write_in;
        read_data_out <= '0;
        valid_out <= 1'b1;
      end
    end else if (mem_ack | expire) begin
      state <= IDLE;
      alu_result_out <= cap_alu;
      write_register_out <= cap_wreg;
      mem_reg_out <= cap_mreg;
      reg_write_out <= mem_ack & cap_rw;
      read_data_out <= (mem_ack & cap_rd & ~cap_wr) ? mem_rdata : '0;
      valid_out <= 1'b1;
      mem_error <= mem_error | ~mem_ack;
    end else begin
      cnt <= cnt + 1'b1;
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized transaction bench with a latency/result reference model
module tb_memory_stage;
  localparam int W = 24, R = 4, TO = 15;
  logic clk = 0, rst = 0, valid_in = 0, mem_read_in = 0, mem_write_in = 0, mem_reg_in = 0, reg_write_in = 0, mem_ack = 0;
  logic [W-1:0] alu_result_in = 0, write_data_in = 0, mem_rdata = 0;
  logic [R-1:0] write_register_in = 0;
  logic stall_out, mem_req, mem_we, mem_reg_out, reg_write_out, valid_out, mem_error;
  logic [W-1:0] mem_addr, mem_wdata, read_data_out, alu_result_out;
  logic [R-1:0] write_register_out;
  int checks = 0, errors = 0;
  logic err_model = 0;
  memory_stage #(.WIDTH(W), .REG_BITS(R), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .write_register_in(write_register_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_reg_in(mem_reg_in),
    .reg_write_in(reg_write_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_register_out(write_register_out), .mem_reg_out(mem_reg_out),
    .reg_write_out(reg_write_out), .valid_out(valid_out), .mem_error(mem_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic scramble_inputs();
    alu_result_in = W'($urandom);
    write_data_in = W'($urandom);
    write_register_in = R'($urandom);
    {mem_read_in, mem_write_in, mem_reg_in, reg_write_in} = 4'($urandom);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_out"}, {read_data_out, alu_result_out}, 0);
    chk({tag, "_ctl"}, {write_register_out, mem_reg_out, reg_write_out, valid_out, mem_error}, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    err_model = 0;
    check_zero("reset");
  endtask
  // delay >= TO means no ack ever arrives; rst_at >= 0 asserts reset in that ACCESS cycle
  task automatic txn(input logic rd, input logic wr, input int delay, input int rst_at,
                     input logic [W-1:0] addr, input logic [W-1:0] wd, input logic [W-1:0] rdat,
                     input logic [R-1:0] wreg, input logic mr, input logic rw);
    int reqs;
    logic memop, tmo;
    logic [W-1:0] exp_rd;
    memop = rd | wr;
    tmo = memop && delay >= TO;
    reqs = 0;
    @(negedge clk);
    valid_in = 1; mem_read_in = rd; mem_write_in = wr; alu_result_in = addr;
    write_data_in = wd; write_register_in = wreg; mem_reg_in = mr; reg_write_in = rw;
    #1 chk("stall_accept", 32'(stall_out), 32'(memop));
    @(posedge clk); #1;
    if (memop) begin
      valid_in = $urandom_range(0, 1) == 1;
      scramble_inputs();
      for (int n = 0; n < TO; n++) begin
        if (mem_req) reqs++;
        chk("addr", mem_addr, addr);
        chk("wdata", mem_wdata, wd);
        chk("we", 32'(mem_we), 32'(wr));
        chk("valid_wait", 32'(valid_out), 0);
        if (n == rst_at) begin
          rst = 1;
          @(posedge clk); #1;
          rst = 0;
          err_model = 0;
          valid_in = 0;
          check_zero("rst_mid");
          @(posedge clk); #1;
          chk("rst_mid_nopulse", 32'(valid_out), 0);
          return;
        end
        mem_rdata = W'($urandom);
        if (n == delay) begin
          mem_ack = 1;
          mem_rdata = rdat;
        end
        #1 chk("stall_wait", 32'(stall_out), 32'(n != delay));
        @(posedge clk); #1;
        mem_ack = 0;
        if (n == delay) break;
      end
      chk("req_cycles", reqs, tmo ? TO : delay + 1);
    end
    valid_in = 0;
    err_model |= tmo;
    exp_rd = (!tmo && rd && !wr) ? rdat : '0;
    chk("valid", 32'(valid_out), 1);
    chk("alu_out", alu_result_out, addr);
    chk("rd_out", read_data_out, exp_rd);
    chk("wreg_out", 32'(write_register_out), 32'(wreg));
    chk("mreg_out", 32'(mem_reg_out), 32'(mr));
    chk("rw_out", 32'(reg_write_out), 32'(rw & ~tmo));
    chk("err", 32'(mem_error), 32'(err_model));
    mem_ack = 1;
    mem_rdata = W'($urandom);
    #1 chk("idle_stall", 32'(stall_out), 0);
    @(posedge clk); #1;
    mem_ack = 0;
    chk("pulse_end", 32'(valid_out), 0);
    chk("idle_req", 32'(mem_req), 0);
    chk("idle_hold", alu_result_out, addr);
    chk("idle_err", 32'(mem_error), 32'(err_model));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    txn(0, 0, 0, -1, 24'h00ABCD, 24'h0, 24'h0, 4'd3, 0, 1);
    txn(1, 0, 0, -1, 24'h000010, 24'h0, 24'h123456, 4'd5, 1, 1);
    txn(0, 1, 3, -1, 24'h000020, 24'hFFFFFF, 24'h0, 4'd2, 0, 0);
    txn(1, 1, 1, -1, 24'h000030, 24'hA5A5A5, 24'h777777, 4'd6, 0, 1);
    txn(1, 0, TO, -1, 24'h000040, 24'h0, 24'h0, 4'd7, 1, 1);
    txn(0, 0, 0, -1, 24'h000055, 24'h0, 24'h0, 4'd8, 0, 1);
    do_reset();
    txn(1, 0, TO - 1, -1, 24'h000060, 24'h0, 24'h654321, 4'd9, 1, 1);
    txn(1, 0, TO, 1, 24'h000070, 24'h0, 24'h0, 4'd1, 1, 1);
    txn(1, 0, 0, -1, 24'h000010, 24'h0, 24'h123456, 4'd5, 1, 1);
    for (int i = 0; i < 60; i++) begin
      logic rd, wr;
      int d;
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 2) == 0;
      d = $urandom_range(0, 4) == 0 ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 5);
      txn(rd, wr, d, -1, W'($urandom), W'($urandom), W'($urandom), R'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL take parameter WIDTH, default 24, as the data/address width.
REQ-002 The block SHALL take parameter REG_BITS, default 4, as the destination register index width.
REQ-003 The block SHALL take parameter TIMEOUT, default 15, as the maximum ACCESS cycles waited for mem_ack.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  instruction present from execute stage
- alu_result_in  in  WIDTH  ALU result / memory address
- write_data_in  in  WIDTH  store data
- write_register_in  in  REG_BITS  destination register
- mem_read_in, mem_write_in, mem_reg_in, reg_write_in  in  1 each  control bits
- stall_out  out  1  hold upstream stages
- mem_req  out  1  data memory request
- mem_we  out  1  write enable
- mem_addr  out  WIDTH  address
- mem_wdata  out  WIDTH  write data
- mem_ack  in  1  memory done
- mem_rdata  in  WIDTH  read data
- read_data_out, alu_result_out  out  WIDTH  to write-back
- write_register_out  out  REG_BITS  to write-back
- mem_reg_out, reg_write_out, valid_out  out  1 each  to write-back
- mem_error  out  1  sticky timeout flag

Function
REQ-006 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-007 IDLE, valid_in=1, no memory op: the block SHALL register alu_result, write_register, mem_reg and reg_write to the outputs, drive read_data_out=0 and valid_out=1 on the next cycle (latency 1).
REQ-008 IDLE, valid_in=1, mem_read_in or mem_write_in set: the block SHALL capture all inputs and enter ACCESS; stall_out SHALL be 1 combinationally in that cycle.
REQ-009 IDLE, valid_in=0: valid_out SHALL be 0 on the next cycle; other outputs SHALL hold.
REQ-010 mem_req SHALL equal (state==ACCESS); mem_addr, mem_wdata and mem_we SHALL be driven from the captured values and stay stable throughout ACCESS.
REQ-011 mem_we SHALL be 1 iff the captured mem_write is set; when mem_read and mem_write are both set, the access SHALL be treated as a store.
REQ-012 In ACCESS, stall_out SHALL be 1 unless mem_ack=1 in that cycle.
REQ-013 In ACCESS with mem_ack=1, on the next edge the block SHALL load the outputs from the captured fields, load read_data_out from mem_rdata for a load (0 for a store), pulse valid_out for one cycle, and return to IDLE.
REQ-014 Minimum load/store latency SHALL be 2 cycles from the accept edge to valid_out when mem_ack arrives in the first ACCESS cycle; each extra wait cycle SHALL add 1.
REQ-015 Inputs SHALL be ignored while in ACCESS; upstream holds them via stall_out.
REQ-016 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-017 If the counter equals TIMEOUT-1 and mem_ack=0, then on the next edge the block SHALL return to IDLE, pulse valid_out with reg_write_out=0, and set mem_error.
REQ-018 mem_error SHALL remain 1 until reset.
REQ-019 A mem_ack arriving in the same cycle as the timeout condition SHALL win: normal completion, no error.
REQ-020 mem_ack received in IDLE SHALL be ignored.

Reset
REQ-021 On a rst=1 edge the block SHALL enter IDLE, clear the counter, and drive every output register to 0 (read_data_out, alu_result_out, write_register_out, mem_reg_out, reg_write_out, valid_out, mem_error).
REQ-022 Reset during ACCESS SHALL abandon the access, drop mem_req after the edge, and produce no valid_out pulse.
REQ-023 rst SHALL take priority over all other inputs.

Verification
REQ-024 ALU op: valid_in=1, alu_result_in=0x00ABCD, write_register_in=3, reg_write_in=1 -> next cycle valid_out=1, alu_result_out=0x00ABCD, write_register_out=3, read_data_out=0, stall_out never 1.
REQ-025 Load, zero wait: mem_read_in=1, alu_result_in=0x000010, ack in first ACCESS cycle with mem_rdata=0x123456 -> mem_addr=0x000010, mem_we=0, stall_out high for 1 cycle, then valid_out=1, read_data_out=0x123456.
REQ-026 Store, 3 wait cycles: mem_write_in=1, write_data_in=0xFFFFFF -> mem_req high 4 cycles, mem_we=1, mem_wdata=0xFFFFFF stable, single valid_out pulse, read_data_out=0.
REQ-027 Timeout: load, no ack -> mem_req high exactly 15 cycles, then valid_out=1 with reg_write_out=0, mem_error=1 held; a following ALU op completes normally with mem_error still 1.
REQ-028 Ack at timeout boundary: ack on 15th ACCESS cycle -> normal completion, mem_error=0.
REQ-029 Reset mid-access: rst=1 on 2nd ACCESS cycle -> mem_req=0 and all outputs 0 after the edge, no valid_out pulse, next load behaves per REQ-025.
